// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set Req bit at or above Rr_Ptr, wrapping.
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [$clog2(NUM_REQ)-1:0] Rr_Ptr,
  output logic                       Valid,
  output logic [$clog2(NUM_REQ)-1:0] Winner
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the closest set bit overwrites the rest.
  always_comb begin
    Valid  = 1'b0;
    Winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(Rr_Ptr) + i) % NUM_REQ);
      if (Req[idx]) begin
        Valid  = 1'b1;
        Winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a start watchdog that raises sticky Arb_Error.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Grant,
  input  logic                           CTS,
  input  logic                           BIST_Busy,
  input  logic                           Tx_Busy,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  output logic [$clog2(NUM_REQ)-1:0]     Active_Id,
  output logic                           Arb_Busy,
  output logic                           Arb_Error
);

  localparam int             IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 start_q, start_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic [IDW-1:0]       id_q,    id_d;
  logic [IDW-1:0]       ptr_q,   ptr_d;

  logic                 rr_valid;
  logic [IDW-1:0]       rr_winner;
  logic                 can_start;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + IDW'(1);
  endfunction

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .Req    (Req),
    .Rr_Ptr (ptr_q),
    .Valid  (rr_valid),
    .Winner (rr_winner)
  );

  // CTS/BIST only gate a new grant; an in-flight transfer ignores them.
  assign can_start = rr_valid & CTS & ~BIST_Busy & ~Tx_Busy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          err_q,   err_d;
  logic [TW-1:0] timer_q, timer_d;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    start_d = start_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
    err_d   = err_q;
    timer_d = '0;
`endif
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (can_start) begin
          data_d  = Req_Data[int'(rr_winner) * DATA_BITS +: DATA_BITS];
          grant_d = NUM_REQ'(1) << rr_winner;
          id_d    = rr_winner;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (Tx_Busy) begin
          start_d = 1'b0;
          state_d = DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          ptr_d   = wrap_inc(id_q);
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      DONE: begin
        if (!Tx_Busy) begin
          ptr_d   = wrap_inc(id_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      err_q   <= err_d;
      timer_q <= timer_d;
`endif
    end
  end

  assign Grant          = grant_q;
  assign Transmit_Start = start_q;
  assign Tx_Data        = data_q;
  assign Active_Id      = id_q;
  assign Arb_Busy       = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
  assign Arb_Error      = err_q;
`else
  assign Arb_Error      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NR-1:0]     Req;
  logic [NR*DB-1:0]  Req_Data;
  logic [NR-1:0]     Grant;
  logic              CTS;
  logic              BIST_Busy;
  logic              Tx_Busy;
  logic [DB-1:0]     Tx_Data;
  logic              Transmit_Start;
  logic [1:0]        Active_Id;
  logic              Arb_Busy;
  logic              Arb_Error;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .DATA_BITS      (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Req            (Req),
    .Req_Data       (Req_Data),
    .Grant          (Grant),
    .CTS            (CTS),
    .BIST_Busy      (BIST_Busy),
    .Tx_Busy        (Tx_Busy),
    .Tx_Data        (Tx_Data),
    .Transmit_Start (Transmit_Start),
    .Active_Id      (Active_Id),
    .Arb_Busy       (Arb_Busy),
    .Arb_Error      (Arb_Error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transfer is "waiting for ack" then "on the wire".
  logic [NR-1:0] m_grant;
  logic          m_start;
  logic [DB-1:0] m_data;
  int            m_id, m_ptr, m_wait;
  bit            m_err, m_wait_ack, m_in_tx;

  function automatic int pick_winner();
    for (int k = 0; k < NR; k++)
      if (Req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return 0;
  endfunction

  task automatic model_step();
    int w;
    if (!Rst) begin
      m_grant = '0; m_start = 0; m_data = '0; m_id = 0; m_ptr = 0;
      m_wait = 0; m_err = 0; m_wait_ack = 0; m_in_tx = 0;
    end else begin
      m_grant = '0;
      if (m_wait_ack) begin
        if (Tx_Busy) begin
          m_start = 0; m_wait_ack = 0; m_in_tx = 1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin
            m_start = 0; m_err = 1; m_ptr = (m_id + 1) % NR; m_wait_ack = 0;
          end
        end
`endif
      end else if (m_in_tx) begin
        if (!Tx_Busy) begin
          m_ptr = (m_id + 1) % NR; m_in_tx = 0;
        end
      end else if (Req != '0 && CTS && !BIST_Busy && !Tx_Busy) begin
        w = pick_winner();
        m_grant = NR'(1) << w;
        m_data = Req_Data[w*DB +: DB];
        m_id = w; m_start = 1; m_wait_ack = 1; m_wait = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    check("grant",     Grant,          m_grant);
    check("start",     Transmit_Start, m_start);
    check("tx_data",   Tx_Data,        m_data);
    check("active_id", Active_Id,      m_id);
    check("arb_busy",  Arb_Busy,       m_wait_ack || m_in_tx);
    check("arb_error", Arb_Error,      m_err);
  endtask

  initial begin
    int n, gcount, busy_left, dly_left;
    Rst = 0; Req = '0; Req_Data = '0; CTS = 0; BIST_Busy = 0; Tx_Busy = 0;
    m_grant = '0; m_start = 0; m_data = '0; m_id = 0; m_ptr = 0;
    m_wait = 0; m_err = 0; m_wait_ack = 0; m_in_tx = 0;
    tick(); tick();
    check("rst_grant", Grant, 0);
    check("rst_busy",  Arb_Busy, 0);

    // Single request with a known byte.
    Rst = 1; Req = 4'b0100; Req_Data = $urandom; Req_Data[23:16] = 8'hA5; CTS = 1;
    tick();
    check("sr_grant", Grant, 4'b0100);
    check("sr_data",  Tx_Data, 8'hA5);
    check("sr_start", Transmit_Start, 1);
    Req = '0; tick();
    check("sr_start_hold", Transmit_Start, 1);
    Tx_Busy = 1; tick();
    check("sr_start_clr", Transmit_Start, 0);
    check("sr_in_done", Arb_Busy, 1);
    Tx_Busy = 0; tick();
    check("sr_idle", Arb_Busy, 0);
    check("sr_data_hold", Tx_Data, 8'hA5);

    // Fairness from reset with all requesters active.
    Rst = 0; tick(); Rst = 1;
    Req = 4'hF; Req_Data = $urandom;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rr_order", Grant, 32'd1 << (t % 4));
      Tx_Busy = 1; tick();
      Tx_Busy = 0; tick();
    end

    // Flow control: CTS low, then BIST busy.
    Req = 4'b0001; CTS = 0; gcount = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (Grant != '0) gcount++;
    end
    check("fc_cts_nogrant", gcount, 0);
    CTS = 1; tick();
    check("fc_cts_grant", Grant, 4'b0001);
    Tx_Busy = 1; tick(); Tx_Busy = 0; tick();
    BIST_Busy = 1; gcount = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (Grant != '0) gcount++;
    end
    check("fc_bist_nogrant", gcount, 0);
    BIST_Busy = 0; tick();
    check("fc_bist_grant", Grant, 4'b0001);
    Tx_Busy = 1; tick(); Tx_Busy = 0; tick();

    // Start watchdog: transmitter never acknowledges.
    Req = 4'b0001; tick(); Req = '0;
    n = 0;
    while (Transmit_Start && n < 40) begin
      tick();
      n++;
    end
`ifdef UART_ARB_TIMEOUT_EN
    check("to_cycles", n, TO);
    check("to_error",  Arb_Error, 1);
    check("to_idle",   Arb_Busy, 0);
`else
    check("to_cycles", n, 40);
    check("to_error",  Arb_Error, 0);
    check("to_waiting", Arb_Busy, 1);
    Tx_Busy = 1; tick(); Tx_Busy = 0; tick();
`endif

    // Reset while the transfer is on the wire.
    Rst = 0; tick(); Rst = 1;
    Req = 4'b0100; tick(); Req = '0;
    Tx_Busy = 1; tick();
    check("mr_in_done", Arb_Busy, 1);
    Rst = 0; tick();
    check("mr_grant", Grant, 0);
    check("mr_start", Transmit_Start, 0);
    check("mr_data",  Tx_Data, 0);
    check("mr_id",    Active_Id, 0);
    check("mr_busy",  Arb_Busy, 0);
    check("mr_error", Arb_Error, 0);
    Rst = 1; Tx_Busy = 0; Req = 4'hF; tick();
    check("mr_first_grant", Grant, 4'b0001);
    Req = '0; Tx_Busy = 1; tick(); Tx_Busy = 0; tick();

    // Random traffic with a reactive transmitter.
    busy_left = 0; dly_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      Rst = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NR; i++) begin
        if (Req[i]) begin
          if (Grant[i] || $urandom_range(0, 59) == 0) Req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          Req[i] = 1'b1;
          Req_Data[i*DB +: DB] = DB'($urandom);
        end
      end
      CTS       = ($urandom_range(0, 5) != 0);
      BIST_Busy = ($urandom_range(0, 7) == 0);
      if (busy_left > 0) begin
        Tx_Busy = 1; busy_left--;
      end else if (Transmit_Start) begin
        if (dly_left == 0) begin
          Tx_Busy = 1; busy_left = $urandom_range(0, 4);
        end else begin
          Tx_Busy = 0; dly_left--;
        end
      end else begin
        Tx_Busy  = ($urandom_range(0, 19) == 0);
        dly_left = ($urandom_range(0, 29) == 0) ? 20 : $urandom_range(0, 3);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8: UART data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum Clk cycles to wait for Tx_Busy after Transmit_Start.
REQ-004 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-005 SHALL have port Clk, input, 1: baud-domain clock; all logic on its rising edge.
REQ-006 SHALL have port Rst, input, 1: synchronous reset, active-low.
REQ-007 SHALL have port Req, input, NUM_REQ: per-requester transmit request, held until Grant.
REQ-008 SHALL have port Req_Data, input, NUM_REQ x DATA_BITS: per-requester byte, stable while Req is high.
REQ-009 SHALL have port Grant, output, NUM_REQ: one-hot, one-cycle pulse when a requester's byte is latched.
REQ-010 SHALL have port CTS, input, 1: 1 permits a new transmission.
REQ-011 SHALL have port BIST_Busy, input, 1: 1 blocks a new transmission.
REQ-012 SHALL have port Tx_Busy, input, 1: transmitter busy flag.
REQ-013 SHALL have port Tx_Data, output, DATA_BITS: byte presented to the transmitter.
REQ-014 SHALL have port Transmit_Start, output, 1: start strobe to the transmitter.
REQ-015 SHALL have port Active_Id, output, $clog2(NUM_REQ): index of the current or last granted requester.
REQ-016 SHALL have port Arb_Busy, output, 1: high in any state except IDLE.
REQ-017 SHALL have port Arb_Error, output, 1: sticky start-timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, START and DONE.
REQ-019 IDLE: if any Req bit is 1, CTS=1, BIST_Busy=0 and Tx_Busy=0, the arbiter SHALL register the following on the next edge: Tx_Data = winner's Req_Data; Grant = onehot(winner) for exactly one cycle; Active_Id = winner; Transmit_Start = 1; state = START.
REQ-020 Winner SHALL be chosen round-robin: the first set Req bit searching upward from pointer Rr_Ptr, wrapping from NUM_REQ-1 to 0.
REQ-021 START: Transmit_Start SHALL stay 1 until Tx_Busy is sampled 1; it SHALL then clear on the next edge, and state SHALL go to DONE.
REQ-022 DONE: when Tx_Busy is sampled 0, Rr_Ptr SHALL become (Active_Id+1) mod NUM_REQ, and state SHALL go to IDLE.
REQ-023 Latency from qualifying Req to Transmit_Start=1 SHALL be exactly 1 cycle; at most one grant SHALL be issued per transmission.
REQ-024 A CTS drop or BIST_Busy rise in START or DONE SHALL NOT abort the transmission; it only blocks the next grant.
REQ-025 A Req deassertion before Grant SHALL cancel that request with no side effects.
REQ-026 Tx_Data SHALL hold its value from grant until the next grant.
REQ-027 In IDLE with no qualifying condition, outputs SHALL hold, and Grant and Transmit_Start SHALL be 0.

Reset
REQ-028 With Rst=0 at a rising edge, the following SHALL apply: state = IDLE; Grant = 0; Transmit_Start = 0; Tx_Data = 0; Active_Id = 0; Rr_Ptr = 0; Arb_Busy = 0; Arb_Error = 0; timeout counter = 0.
REQ-029 Reset SHALL take effect mid-transaction, including in START and DONE, with no completion of the pending handshake.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN SHALL enable a start watchdog.
REQ-031 When the watchdog is enabled: the counter SHALL count START cycles; after TIMEOUT_CYCLES cycles with Tx_Busy=0, the block SHALL clear Transmit_Start, set Arb_Error=1, advance Rr_Ptr and return to IDLE.
REQ-032 When the watchdog is disabled: START SHALL wait indefinitely, and Arb_Error SHALL be tied to 0.

Structure
REQ-033 Shared package uart_pkg SHALL hold the arb_state_t enum (IDLE, START, DONE) and the default constants for DATA_BITS, NUM_REQ and TIMEOUT_CYCLES.
REQ-034 Round-robin selection SHALL be in the sub-module rr_select: combinational inputs Req and Rr_Ptr; outputs Valid and Winner index.

Verification
REQ-035 Single request: Req=4'b0100, Req_Data[2]=8'hA5, CTS=1 -> next cycle Grant=4'b0100, Tx_Data=8'hA5, Transmit_Start=1; Transmit_Start clears 1 cycle after Tx_Busy=1.
REQ-036 Fairness: Req=4'b1111 held for 4 transmissions from reset -> Grant order 0, 1, 2, 3, then wraps to 0.
REQ-037 Flow control: CTS=0 with Req=4'b0001 -> no Grant for 20 cycles; CTS=1 -> Grant=4'b0001 the next cycle. BIST_Busy=1 behaves identically.
REQ-038 Timeout (UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): Tx_Busy tied 0 -> Transmit_Start drops after 16 cycles, Arb_Error=1, FSM in IDLE. Without the macro: Transmit_Start stays 1 and Arb_Error=0.
REQ-039 Mid-operation reset: Rst=0 while in DONE with Tx_Busy=1 -> next edge all outputs at reset values; after release, the first grant goes to requester 0.
